// File: rtl/disp_pkg.sv
// Shared character codes, 14-segment glyphs and controller state type.
// Glyph bit order, MSB first: a b c d e f g1 g2 h i j k l m.
package disp_pkg;

  typedef enum logic [0:0] {StLoad, StShow} disp_state_e;

  localparam logic [4:0] CHAR_SPACE   = 5'd0;
  localparam logic [4:0] CHAR_A       = 5'd1;
  localparam logic [4:0] CHAR_Z       = 5'd26;
  localparam logic [4:0] CHAR_N_TILDE = 5'd27;

  localparam logic [13:0] GLYPH_SPACE   = 14'b00000000000000;
  localparam logic [13:0] GLYPH_A       = 14'b11101111000000;
  localparam logic [13:0] GLYPH_B       = 14'b11110001010010;
  localparam logic [13:0] GLYPH_C       = 14'b10011100000000;
  localparam logic [13:0] GLYPH_D       = 14'b11110000010010;
  localparam logic [13:0] GLYPH_E       = 14'b10011110000000;
  localparam logic [13:0] GLYPH_F       = 14'b10001110000000;
  localparam logic [13:0] GLYPH_G       = 14'b10111101000000;
  localparam logic [13:0] GLYPH_H       = 14'b01101111000000;
  localparam logic [13:0] GLYPH_I       = 14'b10010000010010;
  localparam logic [13:0] GLYPH_J       = 14'b01111000000000;
  localparam logic [13:0] GLYPH_K       = 14'b00001110001100;
  localparam logic [13:0] GLYPH_L       = 14'b00011100000000;
  localparam logic [13:0] GLYPH_M       = 14'b01101100101000;
  localparam logic [13:0] GLYPH_N       = 14'b01101100100100;
  localparam logic [13:0] GLYPH_O       = 14'b11111100000000;
  localparam logic [13:0] GLYPH_P       = 14'b11001111000000;
  localparam logic [13:0] GLYPH_Q       = 14'b11111100000100;
  localparam logic [13:0] GLYPH_R       = 14'b11001111000100;
  localparam logic [13:0] GLYPH_S       = 14'b10110111000000;
  localparam logic [13:0] GLYPH_T       = 14'b10000000010010;
  localparam logic [13:0] GLYPH_U       = 14'b01111100000000;
  localparam logic [13:0] GLYPH_V       = 14'b00001100001001;
  localparam logic [13:0] GLYPH_W       = 14'b01101100000101;
  localparam logic [13:0] GLYPH_X       = 14'b00000000101101;
  localparam logic [13:0] GLYPH_Y       = 14'b00000000101010;
  localparam logic [13:0] GLYPH_Z       = 14'b10010000001001;
  localparam logic [13:0] GLYPH_N_TILDE = 14'b10101011000000;

endpackage

// File: rtl/seg14_font.sv
// Character code to 14-segment glyph lookup; unused codes render blank.
module seg14_font
  import disp_pkg::*;
(
  input  logic [4:0]  code,
  output logic [13:0] glyph
);

  always_comb begin
    glyph = GLYPH_SPACE;
    case (code)
      5'd1:  glyph = GLYPH_A;
      5'd2:  glyph = GLYPH_B;
      5'd3:  glyph = GLYPH_C;
      5'd4:  glyph = GLYPH_D;
      5'd5:  glyph = GLYPH_E;
      5'd6:  glyph = GLYPH_F;
      5'd7:  glyph = GLYPH_G;
      5'd8:  glyph = GLYPH_H;
      5'd9:  glyph = GLYPH_I;
      5'd10: glyph = GLYPH_J;
      5'd11: glyph = GLYPH_K;
      5'd12: glyph = GLYPH_L;
      5'd13: glyph = GLYPH_M;
      5'd14: glyph = GLYPH_N;
      5'd15: glyph = GLYPH_O;
      5'd16: glyph = GLYPH_P;
      5'd17: glyph = GLYPH_Q;
      5'd18: glyph = GLYPH_R;
      5'd19: glyph = GLYPH_S;
      5'd20: glyph = GLYPH_T;
      5'd21: glyph = GLYPH_U;
      5'd22: glyph = GLYPH_V;
      5'd23: glyph = GLYPH_W;
      5'd24: glyph = GLYPH_X;
      5'd25: glyph = GLYPH_Y;
      5'd26: glyph = GLYPH_Z;
      5'd27: glyph = GLYPH_N_TILDE;
      default: glyph = GLYPH_SPACE;
    endcase
  end

endmodule

// File: rtl/disp_scroll_ctrl.sv
// Message loader and multiplexed 14-segment scanner with optional rotation
// of messages longer than the display.
module disp_scroll_ctrl
  import disp_pkg::*;
#(
  parameter int unsigned DIGITS     = 12,
  parameter int unsigned BUF_DEPTH  = 16,
  parameter int unsigned SCAN_DIV   = 1000,
  parameter int unsigned SCROLL_DIV = 50
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [4:0]        wr_char,
  input  logic              wr_last,
  input  logic              scroll_en,
  output logic              busy,
  output logic [DIGITS-1:0] sel,
  output logic [13:0]       segm
);

  localparam int unsigned LW = $clog2(BUF_DEPTH + 1);
  localparam int unsigned AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int unsigned DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned SW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int unsigned FW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int unsigned IW = $clog2(BUF_DEPTH + DIGITS + 1);

  disp_state_e       state_q;
  logic [4:0]        mem_q [BUF_DEPTH];
  logic [LW-1:0]     len_q, offset_q, offset_inc, offset_nxt;
  logic [DW-1:0]     d_q;
  logic [SW-1:0]     scan_q;
  logic [FW-1:0]     frame_q;
  logic [DIGITS-1:0] sel_q;
  logic [13:0]       segm_q, glyph;
  logic [IW-1:0]     sum, idx;
  logic              scan_tc, d_wrap, frame_tc, show_digit, scroll_step, accept;

  // offset < len and d < len whenever rotation is active, so one subtract wraps the index
  assign sum = IW'(offset_q) + IW'(d_q);
  assign idx = (sum >= IW'(len_q)) ? sum - IW'(len_q) : sum;

  seg14_font u_font (
    .code  (mem_q[idx[AW-1:0]]),
    .glyph (glyph)
  );

  assign scan_tc     = (scan_q == SW'(SCAN_DIV - 1));
  assign d_wrap      = (d_q == DW'(DIGITS - 1));
  assign frame_tc    = (frame_q == FW'(SCROLL_DIV - 1));
  assign show_digit  = (32'(d_q) < 32'(len_q)) || (32'(len_q) > DIGITS);
  assign scroll_step = scan_tc && d_wrap && frame_tc && (state_q == StShow) && scroll_en &&
                       (32'(len_q) > DIGITS);
  assign offset_inc  = offset_q + LW'(1);
  assign offset_nxt  = (offset_inc == len_q) ? '0 : offset_inc;

  assign wr_ready = (state_q == StLoad) && !clr;
  assign accept   = wr_valid && wr_ready;
  assign busy     = (state_q == StShow);
  assign sel      = sel_q;
  assign segm     = segm_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StLoad;
      len_q    <= '0;
      offset_q <= '0;
      d_q      <= '0;
      scan_q   <= '0;
      frame_q  <= '0;
      sel_q    <= '0;
      segm_q   <= '0;
    end else begin
      if (scan_tc) begin
        scan_q <= '0;
        sel_q  <= DIGITS'(1) << d_q;
        segm_q <= ((state_q == StShow) && show_digit) ? glyph : '0;
        d_q    <= d_wrap ? '0 : d_q + DW'(1);
        if (d_wrap) frame_q <= frame_tc ? '0 : frame_q + FW'(1);
      end else begin
        scan_q <= scan_q + SW'(1);
      end
      // Offset only moves as d wraps, so the next frame starts with the new value
      if (scroll_step) offset_q <= offset_nxt;
      if (clr) begin
        state_q  <= StLoad;
        len_q    <= '0;
        offset_q <= '0;
        segm_q   <= '0;
      end else if (accept) begin
        mem_q[len_q[AW-1:0]] <= wr_char;
        len_q                <= len_q + LW'(1);
        if (wr_last || (len_q == LW'(BUF_DEPTH - 1))) state_q <= StShow;
      end
    end
  end

endmodule

// File: tb/tb_disp_scroll_ctrl.sv
// Directed bench for disp_scroll_ctrl with a cycle-level message/scan model.
module tb_disp_scroll_ctrl;

  localparam int DIGITS     = 12;
  localparam int BUF_DEPTH  = 16;
  localparam int SCAN_DIV   = 2;
  localparam int SCROLL_DIV = 1;

  localparam logic [13:0] FONT [32] = '{
    14'b00000000000000, 14'b11101111000000, 14'b11110001010010, 14'b10011100000000,
    14'b11110000010010, 14'b10011110000000, 14'b10001110000000, 14'b10111101000000,
    14'b01101111000000, 14'b10010000010010, 14'b01111000000000, 14'b00001110001100,
    14'b00011100000000, 14'b01101100101000, 14'b01101100100100, 14'b11111100000000,
    14'b11001111000000, 14'b11111100000100, 14'b11001111000100, 14'b10110111000000,
    14'b10000000010010, 14'b01111100000000, 14'b00001100001001, 14'b01101100000101,
    14'b00000000101101, 14'b00000000101010, 14'b10010000001001, 14'b10101011000000,
    14'b00000000000000, 14'b00000000000000, 14'b00000000000000, 14'b00000000000000
  };

  logic              clk = 1'b0;
  logic              rst, clr, wr_valid, wr_ready, wr_last, scroll_en, busy;
  logic [4:0]        wr_char;
  logic [DIGITS-1:0] sel;
  logic [13:0]       segm;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  disp_scroll_ctrl #(
    .DIGITS     (DIGITS),
    .BUF_DEPTH  (BUF_DEPTH),
    .SCAN_DIV   (SCAN_DIV),
    .SCROLL_DIV (SCROLL_DIV)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .clr       (clr),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_char   (wr_char),
    .wr_last   (wr_last),
    .scroll_en (scroll_en),
    .busy      (busy),
    .sel       (sel),
    .segm      (segm)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: message as a queue, display slot from elapsed cycles since reset
  bit                m_ok = 1'b0;
  bit                m_show;
  logic [4:0]        msg [$];
  int                m_off, m_frames, n, m_dg, m_ln;
  bit                m_prev_show;
  logic [DIGITS-1:0] e_sel;
  logic [13:0]       e_segm;

  always @(posedge clk) begin
    if (rst) begin
      m_ok     = 1'b1;
      n        = 0;
      m_show   = 1'b0;
      msg.delete();
      m_off    = 0;
      m_frames = 0;
      e_sel    = '0;
      e_segm   = '0;
    end else begin
      m_prev_show = m_show;
      m_ln        = msg.size();
      n++;
      if (n % SCAN_DIV == 0) begin
        m_dg        = (n / SCAN_DIV - 1) % DIGITS;
        e_sel       = '0;
        e_sel[m_dg] = 1'b1;
        if (m_prev_show && (m_dg < m_ln || m_ln > DIGITS))
          e_segm = FONT[msg[(m_off + m_dg) % m_ln]];
        else
          e_segm = '0;
        if (m_dg == DIGITS - 1) begin
          if (m_frames == SCROLL_DIV - 1) begin
            m_frames = 0;
            if (m_prev_show && scroll_en && m_ln > DIGITS) m_off = (m_off + 1) % m_ln;
          end else begin
            m_frames++;
          end
        end
      end
      if (clr) begin
        m_show = 1'b0;
        msg.delete();
        m_off  = 0;
        e_segm = '0;
      end else if (!m_prev_show && wr_valid) begin
        msg.push_back(wr_char);
        if (wr_last || msg.size() == BUF_DEPTH) m_show = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (m_ok) begin
      check("busy", 32'(busy), 32'(m_show));
      check("sel", 32'(sel), 32'(e_sel));
      check("segm", 32'(segm), 32'(e_segm));
      check("wr_ready", 32'(wr_ready), 32'(!m_show && !clr));
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic write(input logic [4:0] c, input logic last);
    wr_valid = 1'b1;
    wr_char  = c;
    wr_last  = last;
    step();
    wr_valid = 1'b0;
    wr_last  = 1'b0;
  endtask

  // Advance to the start of the next frame (digit 0 selected)
  task automatic wait_frame();
    int k;
    k = 0;
    while (sel == DIGITS'(1) && k < 200) begin step(); k++; end
    while (sel != DIGITS'(1) && k < 200) begin step(); k++; end
    if (k >= 200) check("frame_timeout", 32'(k), 32'd0);
  endtask

  logic [4:0] pina [4];
  int         j;

  initial begin
    pina = '{5'd16, 5'd9, 5'd27, 5'd1};
    rst = 1'b1; clr = 1'b0; wr_valid = 1'b0; wr_char = '0; wr_last = 1'b0; scroll_en = 1'b0;
    repeat (3) step();
    check("rst_sel", 32'(sel), 32'd0);
    check("rst_segm", 32'(segm), 32'd0);
    rst = 1'b0;
    step();
    check("sel_1cyc", 32'(sel), 32'd0);
    step();
    check("sel_first", 32'(sel), 32'd1);
    repeat (30) step();

    // Short message: no rotation even with scroll_en
    scroll_en = 1'b1;
    for (int i = 0; i < 4; i++) write(pina[i], i == 3);
    check("busy_pina", 32'(busy), 32'd1);
    wait_frame();
    check("d0_P", 32'(segm), 32'b11001111000000);
    step(); step();
    check("sel_d1", 32'(sel), 32'd2);
    check("d1_I", 32'(segm), 32'b10010000010010);
    step(); step();
    check("d2_Ntilde", 32'(segm), 32'b10101011000000);
    step(); step();
    check("d3_A", 32'(segm), 32'b11101111000000);
    step(); step();
    check("d4_blank", 32'(segm), 32'd0);
    wait_frame();
    wait_frame();
    check("d0_P_noscroll", 32'(segm), 32'b11001111000000);

    // clr in SHOW mid-frame
    repeat (5) step();
    clr = 1'b1;
    step();
    clr = 1'b0;
    check("clr_busy", 32'(busy), 32'd0);
    check("clr_segm", 32'(segm), 32'd0);

    // clr with a concurrent write drops it; next message starts at buffer[0]
    write(5'd5, 1'b0);
    write(5'd6, 1'b0);
    clr = 1'b1; wr_valid = 1'b1; wr_char = 5'd26;
    step();
    clr = 1'b0; wr_valid = 1'b0;
    for (int i = 1; i <= 14; i++) write(5'(i), i == 14);
    wait_frame();
    j = 0;
    for (int i = 1; i <= 14; i++) if (FONT[i] == segm) j = i;
    check("scroll_start_found", 32'(j != 0), 32'd1);
    if (j == 0) j = 1;
    for (int f = 1; f <= 14; f++) begin
      wait_frame();
      check("scroll_frame", 32'(segm), 32'(FONT[((j - 1 + f) % 14) + 1]));
    end

    // Full buffer without wr_last
    clr = 1'b1;
    step();
    clr = 1'b0;
    for (int i = 0; i < 16; i++) write(5'(i + 1), 1'b0);
    check("full_busy", 32'(busy), 32'd1);
    wr_valid = 1'b1; wr_char = 5'd26;
    check("full_ready", 32'(wr_ready), 32'd0);
    step();
    wr_valid = 1'b0;
    repeat (60) step();

    // Reset mid-frame
    repeat (3) step();
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    check("rerst_sel0", 32'(sel), 32'd0);
    check("rerst_busy", 32'(busy), 32'd0);
    step();
    check("rerst_sel1", 32'(sel), 32'd1);
    repeat (4) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
